uart_tx_buffered: RTL

- UART transmitter with a 4-entry input FIFO, the transmit half of the UART pair; it drives the `tx` pin of `UART_top`.
- Accepts bytes on a single-cycle `tx_start` strobe and serialises each one as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Each bit lasts exactly `CLOCK_PER_BIT` clocks.
- Buffering allows back-to-back frames with no idle gap on the line.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync_fifo.sv | 66 ++++++
 rtl/uart_tx_buffered.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter, receiver and their benches.
package uart_pkg;

  localparam int UART_DATA_BITS     = 8;
  localparam int UART_CLOCK_PER_BIT = 10416;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with a registered occupancy count and a head word
// that is valid in the same cycle it is popped.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q;
  logic [PTR_W-1:0] rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             doPush;
  logic             doPop;

  // A push is refused while full even if a pop happens on the same edge.
  assign doPush  = push_i & ~full_o;
  assign doPop   = pop_i & ~empty_o;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop) begin
      count_d = count_q + 1'b1;
    end else if (!doPush && doPop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        wrPtr_q <= wrPtr_q + 1'b1;
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a serialiser
// that chains frames back to back whenever data is waiting.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_PER_BIT = UART_CLOCK_PER_BIT,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tx_start,
  input  logic [UART_DATA_BITS-1:0] tx_data,
  output logic                      tx_full,
  output logic                      tx_busy,
  output logic                      tx_drop,
  output logic                      tx
);

  localparam int BAUD_W = (CLOCK_PER_BIT > 1) ? $clog2(CLOCK_PER_BIT) : 1;
  localparam int BIT_W  = $clog2(UART_DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCK_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);

  uart_tx_state_t            state_q;
  logic [BAUD_W-1:0]         baudCnt_q;
  logic [BIT_W-1:0]          bitCnt_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      tx_q;
  logic                      drop_q;

  logic                      baudLast;
  logic                      fifoPop;
  logic                      fifoFull;
  logic                      fifoEmpty;
  logic [UART_DATA_BITS-1:0] fifoHead;

  uart_sync_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (tx_start),
    .data_i (tx_data),
    .pop_i  (fifoPop),
    .head_o (fifoHead),
    .full_o (fifoFull),
    .empty_o(fifoEmpty)
  );

  assign baudLast = (baudCnt_q == BAUD_LAST);
  // Popping at the end of STOP lets the next start bit follow with no idle gap.
  assign fifoPop  = ~fifoEmpty & ((state_q == IDLE) | ((state_q == STOP) & baudLast));

  assign tx       = tx_q;
  assign tx_drop  = drop_q;
  assign tx_full  = fifoFull;
  assign tx_busy  = (state_q != IDLE) | ~fifoEmpty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      drop_q    <= tx_start & fifoFull;
      baudCnt_q <= baudLast ? '0 : baudCnt_q + 1'b1;
      case (state_q)
        IDLE: begin
          baudCnt_q <= '0;
          bitCnt_q  <= '0;
          if (!fifoEmpty) begin
            shift_q <= fifoHead;
            tx_q    <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baudLast) begin
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end
        end
        DATA: begin
          if (baudLast) begin
            shift_q  <= shift_q >> 1;
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        STOP: begin
          if (baudLast) begin
            if (!fifoEmpty) begin
              shift_q <= fifoHead;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
